i2c_slave_rx_writer: RTL and testbench

- I2C slave receive front-end that sits directly upstream of the write port of the dual-clock FIFO.
- Samples SCL/SDA in the write_clk domain, detects START/STOP, and matches the 7-bit slave address with R/W=0.
- Deserialises each data byte and pushes it into the FIFO with a one-cycle write_enable pulse.
- Generates ACK when the byte is accepted and NACK when the FIFO reports write_full.

---
 rtl/i2c_slave_rx_writer.sv | 161 ++++++++++++++++
 tb/tb_i2c_slave_rx_writer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_rx_writer.sv
// I2C slave receive front-end: detects START/STOP, matches a 7-bit write address,
// and pushes each received data byte into a FIFO write port, ACKing or NACKing on FIFO full.
module i2c_slave_rx_writer #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42,
  parameter int         DATA_SIZE  = 8
) (
  input  logic                 write_clk,
  input  logic                 write_reset_n,
  input  logic                 scl_in,
  input  logic                 sda_in,
  output logic                 sda_oe,
  output logic [DATA_SIZE-1:0] write_data,
  output logic                 write_enable,
  input  logic                 write_full,
  output logic                 rx_overflow,
  input  logic                 overflow_clr,
  output logic                 busy
);

  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE} state_t;

  state_t               r_state, w_stateNext;
  logic                 r_sclMeta, r_sclSync, r_sclHist;
  logic                 r_sdaMeta, r_sdaSync, r_sdaHist;
  logic [3:0]           r_bitCnt, w_bitCntNext;
  logic [DATA_SIZE-1:0] r_shift, w_shiftNext, w_shifted;
  logic                 r_ackPhase, w_ackPhaseNext;
  logic                 r_ackEn, w_ackEnNext;
  logic                 w_sdaOeNext, w_writeEnNext, w_busyNext, w_overflowNext;
  logic [DATA_SIZE-1:0] w_writeDataNext;
  logic                 w_sclRise, w_sclFall, w_start, w_stop, w_byteDone, w_addrMatch;

  // Synchronisers idle high so a reset does not look like bus activity.
  always_ff @(posedge write_clk or negedge write_reset_n) begin
    if (!write_reset_n) begin
      {r_sclMeta, r_sclSync, r_sclHist} <= 3'b111;
      {r_sdaMeta, r_sdaSync, r_sdaHist} <= 3'b111;
    end else begin
      {r_sclMeta, r_sclSync, r_sclHist} <= {scl_in, r_sclMeta, r_sclSync};
      {r_sdaMeta, r_sdaSync, r_sdaHist} <= {sda_in, r_sdaMeta, r_sdaSync};
    end
  end

  assign w_sclRise   = r_sclSync & ~r_sclHist;
  assign w_sclFall   = ~r_sclSync & r_sclHist;
  assign w_start     = r_sclHist & r_sdaHist & ~r_sdaSync;
  assign w_stop      = r_sclHist & ~r_sdaHist & r_sdaSync;
  assign w_shifted   = {r_shift[DATA_SIZE-2:0], r_sdaSync};
  assign w_byteDone  = w_sclRise && (r_bitCnt == 4'd7);
  assign w_addrMatch = (w_shifted[7:1] == SLAVE_ADDR) && !w_shifted[0];

  always_ff @(posedge write_clk or negedge write_reset_n) begin
    if (!write_reset_n) r_state <= IDLE;
    else                r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    if (w_stop) begin
      w_stateNext = IDLE;
    end else if (w_start) begin
      w_stateNext = ADDR;
    end else begin
      case (r_state)
        ADDR:     if (w_byteDone) w_stateNext = w_addrMatch ? ADDR_ACK : IGNORE;
        ADDR_ACK: if (w_sclFall && r_ackPhase) w_stateNext = DATA;
        DATA:     if (w_byteDone) w_stateNext = DATA_ACK;
        DATA_ACK: if (w_sclFall && r_ackPhase) w_stateNext = r_ackEn ? DATA : IGNORE;
        default:  w_stateNext = r_state;
      endcase
    end
  end

  // Next values of the registered outputs and datapath; r_ackPhase splits the 9th clock into its low and high halves.
  always_comb begin
    w_sdaOeNext     = sda_oe;
    w_writeEnNext   = 1'b0;
    w_writeDataNext = write_data;
    w_busyNext      = busy;
    w_overflowNext  = rx_overflow;
    w_bitCntNext    = r_bitCnt;
    w_shiftNext     = r_shift;
    w_ackPhaseNext  = r_ackPhase;
    w_ackEnNext     = r_ackEn;
    if (w_stop) begin
      w_sdaOeNext    = 1'b0;
      w_busyNext     = 1'b0;
      w_bitCntNext   = '0;
      w_shiftNext    = '0;
      w_ackPhaseNext = 1'b0;
    end else if (w_start) begin
      w_sdaOeNext    = 1'b0;
      w_bitCntNext   = '0;
      w_shiftNext    = '0;
      w_ackPhaseNext = 1'b0;
    end else begin
      case (r_state)
        ADDR, DATA: begin
          if (w_sclRise && (r_bitCnt < 4'd8)) begin
            w_shiftNext  = w_shifted;
            w_bitCntNext = r_bitCnt + 4'd1;
          end
          if (w_byteDone) begin
            w_ackPhaseNext = 1'b0;
            if (r_state == ADDR) begin
              w_busyNext  = w_addrMatch;
              w_ackEnNext = w_addrMatch;
            end else if (!write_full) begin
              w_writeEnNext   = 1'b1;
              w_writeDataNext = w_shifted;
              w_ackEnNext     = 1'b1;
            end else begin
              w_overflowNext = 1'b1;
              w_ackEnNext    = 1'b0;
            end
          end
        end
        ADDR_ACK, DATA_ACK: begin
          if (w_sclFall) begin
            if (!r_ackPhase) begin
              w_ackPhaseNext = 1'b1;
              w_sdaOeNext    = r_ackEn;
            end else begin
              w_ackPhaseNext = 1'b0;
              w_sdaOeNext    = 1'b0;
              w_bitCntNext   = '0;
            end
          end
        end
        IGNORE:  w_sdaOeNext = 1'b0;
        default: w_sdaOeNext = sda_oe;
      endcase
    end
    if (overflow_clr) w_overflowNext = 1'b0;
  end

  always_ff @(posedge write_clk or negedge write_reset_n) begin
    if (!write_reset_n) begin
      sda_oe       <= 1'b0;
      write_enable <= 1'b0;
      write_data   <= '0;
      busy         <= 1'b0;
      rx_overflow  <= 1'b0;
      r_bitCnt     <= '0;
      r_shift      <= '0;
      r_ackPhase   <= 1'b0;
      r_ackEn      <= 1'b0;
    end else begin
      sda_oe       <= w_sdaOeNext;
      write_enable <= w_writeEnNext;
      write_data   <= w_writeDataNext;
      busy         <= w_busyNext;
      rx_overflow  <= w_overflowNext;
      r_bitCnt     <= w_bitCntNext;
      r_shift      <= w_shiftNext;
      r_ackPhase   <= w_ackPhaseNext;
      r_ackEn      <= w_ackEnNext;
    end
  end

endmodule

// File: tb/tb_i2c_slave_rx_writer.sv
// Bench for i2c_slave_rx_writer: a bit-banged I2C master drives the slave while a
// scoreboard queue of expected FIFO bytes is compared against the captured write_enable pushes.
module tb_i2c_slave_rx_writer;

  localparam int Q = 50;

  logic       write_clk = 1'b0;
  logic       write_reset_n = 1'b0;
  logic       scl = 1'b1;
  logic       sdaM = 1'b1;
  logic       sda_oe;
  logic [7:0] write_data;
  logic       write_enable;
  logic       write_full = 1'b0;
  logic       rx_overflow;
  logic       overflow_clr = 1'b0;
  logic       busy;
  logic       sdaLine;

  int         checks = 0;
  int         errors = 0;
  int         oeCount = 0;
  int         rdIdx = 0;
  logic [7:0] expQ[$];
  logic [7:0] gotQ[$];
  logic [7:0] expByte;
  logic       ack;
  int         oeBefore;

  assign sdaLine = sdaM & ~sda_oe;

  i2c_slave_rx_writer #(.SLAVE_ADDR(7'h42), .DATA_SIZE(8)) dut (
    .write_clk(write_clk), .write_reset_n(write_reset_n), .scl_in(scl), .sda_in(sdaLine),
    .sda_oe(sda_oe), .write_data(write_data), .write_enable(write_enable),
    .write_full(write_full), .rx_overflow(rx_overflow), .overflow_clr(overflow_clr), .busy(busy)
  );

  always #5 write_clk = ~write_clk;

  // Captures every push and counts ACK-driving cycles, sampled away from the active edge.
  always @(negedge write_clk) begin
    if (write_enable) gotQ.push_back(write_data);
    if (sda_oe) oeCount++;
  end

  task automatic i2cStart();
    #Q sdaM = 1'b1;
    #Q scl = 1'b1;
    #Q sdaM = 1'b0;
    #Q scl = 1'b0;
  endtask

  task automatic i2cStop();
    #Q sdaM = 1'b0;
    #Q scl = 1'b1;
    #Q sdaM = 1'b1;
    #Q;
  endtask

  task automatic sendBit(input logic b);
    #Q sdaM = b;
    #Q scl = 1'b1;
    #(2*Q) scl = 1'b0;
  endtask

  task automatic sendBits(input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) sendBit(d[7-i]);
  endtask

  task automatic sendByte(input logic [7:0] d, output logic ackOut);
    sendBits(d, 8);
    #Q sdaM = 1'b1;
    #Q scl = 1'b1;
    #Q ackOut = sda_oe;
    #Q scl = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge write_clk);
    @(negedge write_clk);
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("[TB] FAIL reset_sda_oe: got %b, required 0", sda_oe); end
    checks++; if (write_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_write_data: got %h, required 00", write_data); end
    checks++; if (write_enable !== 1'b0) begin errors++; $display("[TB] FAIL reset_write_enable: got %b, required 0", write_enable); end
    checks++; if (rx_overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_rx_overflow: got %b, required 0", rx_overflow); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b, required 0", busy); end
    write_reset_n = 1'b1;
    repeat (5) @(posedge write_clk);
  endtask

  task automatic test_write_two();
    i2cStart();
    sendByte({7'h42, 1'b0}, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL two_addr_ack: got %b, required 1", ack); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL two_busy_set: got %b, required 1", busy); end
    expQ.push_back(8'hA5);
    sendByte(8'hA5, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL two_a5_ack: got %b, required 1", ack); end
    expQ.push_back(8'h3C);
    sendByte(8'h3C, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL two_3c_ack: got %b, required 1", ack); end
    i2cStop();
    #(2*Q);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL two_busy_clear: got %b, required 0", busy); end
    checks++; if (rx_overflow !== 1'b0) begin errors++; $display("[TB] FAIL two_overflow: got %b, required 0", rx_overflow); end
    while (rdIdx < gotQ.size()) begin
      checks++;
      if (expQ.size() == 0) begin errors++; $display("[TB] FAIL two_unexpected_write: got %h, required no write", gotQ[rdIdx]); end
      else begin expByte = expQ.pop_front(); if (gotQ[rdIdx] !== expByte) begin errors++; $display("[TB] FAIL two_write_data: got %h, required %h", gotQ[rdIdx], expByte); end end
      rdIdx++;
    end
    checks++; if (expQ.size() != 0) begin errors++; $display("[TB] FAIL two_missing_write: %0d pushes outstanding, required 0", expQ.size()); expQ.delete(); end
  endtask

  task automatic test_wrong_addr();
    oeBefore = oeCount;
    i2cStart();
    sendByte({7'h43, 1'b0}, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("[TB] FAIL wrong_addr_ack: got %b, required 0", ack); end
    sendByte(8'hFF, ack);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL wrong_busy: got %b, required 0", busy); end
    i2cStop();
    #(2*Q);
    checks++; if (oeCount != oeBefore) begin errors++; $display("[TB] FAIL wrong_sda_oe: got %0d driven cycles, required 0", oeCount - oeBefore); end
    checks++; if (gotQ.size() != rdIdx) begin errors++; $display("[TB] FAIL wrong_writes: got %0d pushes, required 0", gotQ.size() - rdIdx); rdIdx = gotQ.size(); end
  endtask

  task automatic test_read_addr();
    oeBefore = oeCount;
    i2cStart();
    sendByte({7'h42, 1'b1}, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("[TB] FAIL read_ack: got %b, required 0", ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL read_busy: got %b, required 0", busy); end
    sendByte(8'h55, ack);
    i2cStop();
    #(2*Q);
    checks++; if (oeCount != oeBefore) begin errors++; $display("[TB] FAIL read_sda_oe: got %0d driven cycles, required 0", oeCount - oeBefore); end
    checks++; if (gotQ.size() != rdIdx) begin errors++; $display("[TB] FAIL read_writes: got %0d pushes, required 0", gotQ.size() - rdIdx); rdIdx = gotQ.size(); end
  endtask

  task automatic test_full();
    i2cStart();
    sendByte({7'h42, 1'b0}, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL full_addr_ack: got %b, required 1", ack); end
    expQ.push_back(8'h77);
    sendByte(8'h77, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL full_first_ack: got %b, required 1", ack); end
    write_full = 1'b1;
    sendByte(8'h11, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("[TB] FAIL full_nack: got %b, required 0", ack); end
    checks++; if (rx_overflow !== 1'b1) begin errors++; $display("[TB] FAIL full_overflow_set: got %b, required 1", rx_overflow); end
    i2cStop();
    write_full = 1'b0;
    #(2*Q);
    checks++; if (rx_overflow !== 1'b1) begin errors++; $display("[TB] FAIL full_overflow_sticky: got %b, required 1", rx_overflow); end
    @(posedge write_clk); #1 overflow_clr = 1'b1;
    @(posedge write_clk); #1 overflow_clr = 1'b0;
    checks++; if (rx_overflow !== 1'b0) begin errors++; $display("[TB] FAIL full_overflow_clr: got %b, required 0", rx_overflow); end
    while (rdIdx < gotQ.size()) begin
      checks++;
      if (expQ.size() == 0) begin errors++; $display("[TB] FAIL full_unexpected_write: got %h, required no write", gotQ[rdIdx]); end
      else begin expByte = expQ.pop_front(); if (gotQ[rdIdx] !== expByte) begin errors++; $display("[TB] FAIL full_write_data: got %h, required %h", gotQ[rdIdx], expByte); end end
      rdIdx++;
    end
    checks++; if (expQ.size() != 0) begin errors++; $display("[TB] FAIL full_missing_write: %0d pushes outstanding, required 0", expQ.size()); expQ.delete(); end
  endtask

  task automatic test_partial();
    i2cStart();
    sendByte({7'h42, 1'b0}, ack);
    sendBits(8'hB7, 5);
    i2cStop();
    #(2*Q);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL partial_busy: got %b, required 0", busy); end
    i2cStart();
    sendByte({7'h42, 1'b0}, ack);
    sendBits(8'hC3, 3);
    i2cStart();
    sendByte({7'h42, 1'b0}, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL partial_restart_ack: got %b, required 1", ack); end
    expQ.push_back(8'h6E);
    sendByte(8'h6E, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL partial_byte_ack: got %b, required 1", ack); end
    i2cStop();
    #(2*Q);
    while (rdIdx < gotQ.size()) begin
      checks++;
      if (expQ.size() == 0) begin errors++; $display("[TB] FAIL partial_unexpected_write: got %h, required no write", gotQ[rdIdx]); end
      else begin expByte = expQ.pop_front(); if (gotQ[rdIdx] !== expByte) begin errors++; $display("[TB] FAIL partial_write_data: got %h, required %h", gotQ[rdIdx], expByte); end end
      rdIdx++;
    end
    checks++; if (expQ.size() != 0) begin errors++; $display("[TB] FAIL partial_missing_write: %0d pushes outstanding, required 0", expQ.size()); expQ.delete(); end
  endtask

  task automatic test_reset_mid();
    i2cStart();
    sendByte({7'h42, 1'b0}, ack);
    expQ.push_back(8'h5A);
    sendBits(8'h5A, 8);
    #Q sdaM = 1'b1;
    #Q scl = 1'b1;
    #Q;
    checks++; if (sda_oe !== 1'b1) begin errors++; $display("[TB] FAIL mid_ack_active: got %b, required 1", sda_oe); end
    write_reset_n = 1'b0;
    #1;
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("[TB] FAIL mid_sda_release: got %b, required 0", sda_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_busy: got %b, required 0", busy); end
    #Q scl = 1'b0;
    #Q write_reset_n = 1'b1;
    i2cStart();
    sendByte({7'h42, 1'b0}, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL mid_addr_ack: got %b, required 1", ack); end
    expQ.push_back(8'h01);
    sendByte(8'h01, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL mid_byte_ack: got %b, required 1", ack); end
    i2cStop();
    #(2*Q);
    while (rdIdx < gotQ.size()) begin
      checks++;
      if (expQ.size() == 0) begin errors++; $display("[TB] FAIL mid_unexpected_write: got %h, required no write", gotQ[rdIdx]); end
      else begin expByte = expQ.pop_front(); if (gotQ[rdIdx] !== expByte) begin errors++; $display("[TB] FAIL mid_write_data: got %h, required %h", gotQ[rdIdx], expByte); end end
      rdIdx++;
    end
    checks++; if (expQ.size() != 0) begin errors++; $display("[TB] FAIL mid_missing_write: %0d pushes outstanding, required 0", expQ.size()); expQ.delete(); end
  endtask

  initial begin
    test_reset();
    test_write_two();
    test_wrong_addr();
    test_read_addr();
    test_full();
    test_partial();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
